incubator_plant: RTL and testbench
==================================

Name: incubator_plant

Overview:
- Synthesizable thermal model of the incubator chamber; closes the loop around the incubator controller.
- Consumes the controller's heater_on / cooler_on / fan_speed outputs and produces the signed 8-bit temperature the controller samples.
- Used in closed-loop benches and in FPGA self-test builds in place of a real sensor.
- Supports forced temperature injection and a configurable sensor latency.

Parameters:
- INIT_TEMP, 25: internal temperature after reset (signed 8-bit, °C).
- AMBIENT, 25: temperature the chamber drifts toward when idle.
- TICK_DIV, 4: clock cycles per thermal update; legal range 2..255.
- HEAT_STEP, 1: °C added per tick while heating.
- COOL_STEP, 1: °C removed per tick per fan level while cooling.
- TMIN, -40: lower saturation bound.
- TMAX, 100: upper saturation bound.
- SENSE_LAT, 2: sensor delay in cycles; legal range 0..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- heater_on  in  1  heater command from controller.
- cooler_on  in  1  cooler command from controller.
- fan_speed  in  4  fan command; fan level = fan_speed[3:2]+1, giving 1..4.
- set_valid  in  1  force-temperature strobe, sampled on clk.
- set_temp  in  8  signed forced temperature.
- temperature  out  8  signed sensed temperature: internal temperature delayed SENSE_LAT cycles.
- tick  out  1  one-cycle pulse in the cycle after each thermal update.
- mode  out  2  IDLE=0, HEATING=1, COOLING=2, FAULT=3; updated at each tick.
- conflict  out  1  sticky flag set when heater_on and cooler_on are seen together at a tick.

Behaviour:
- Reset (reset=0, asynchronous):
  - Internal temp = INIT_TEMP; every delay stage = INIT_TEMP, so temperature = INIT_TEMP.
  - Divider counter = 0; tick=0, mode=IDLE, conflict=0.
- Divider:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - A thermal update occurs on the edge where counter==TICK_DIV-1. tick is asserted the following cycle for exactly one cycle.
- Thermal update (inputs sampled at the update edge), computed in 10-bit signed, then saturated to [TMIN,TMAX]:
  - heater only: +HEAT_STEP; mode=HEATING.
  - cooler only: -(COOL_STEP × fan level); mode=COOLING.
  - both: temp held; mode=FAULT; conflict←1.
  - neither: drift 1 °C toward AMBIENT (+1 if below, -1 if above, 0 if equal); mode=IDLE.
- FAULT is not sticky: mode leaves FAULT at the next tick where inputs are legal. conflict clears only on reset.
- Force:
  - set_valid=1 at an edge loads saturate(set_temp) into internal temp and resets the counter to 0.
  - Force wins over a coincident update: no delta is applied, no tick is generated, mode is unchanged.
  - The next update occurs TICK_DIV cycles after the force edge.
- Sensor delay:
  - temperature = internal temp from SENSE_LAT cycles earlier.
  - SENSE_LAT=0 drives the internal register straight to the output.
  - The delay line shifts every cycle, independent of tick.
- Boundaries:
  - Saturation holds at TMAX/TMIN with no wrap.
  - set_temp outside [TMIN,TMAX] is clamped.
  - Reset mid-tick discards the pending update and refills the delay line with INIT_TEMP.

Decomposition:
- Package incubator_pkg:
  - mode encodings (IDLE/HEATING/COOLING/FAULT);
  - temperature width (8);
  - default TMIN/TMAX;
  - the fan-level function, shared with the controller.
- Sub-module sensor_delay_line:
  - parameters SENSE_LAT and width;
  - reset-fill value supplied as a port or parameter.
- Divider, update logic and mode/conflict registers stay in the top module.

Test Plan (all with default parameters unless noted; 10 ns clock):
- Reset released, heater=cooler=0 for 40 cycles -> temperature stays 25, mode=IDLE, tick every 4th cycle (10 pulses), conflict=0.
- heater_on=1 for 10 ticks from 25 -> internal temp 35; temperature reaches 35 exactly 2 cycles after the 10th update edge; mode=HEATING.
- From 35: cooler_on=1, fan_speed=8 (level 3), 5 ticks -> 20, mode=COOLING. Then fan_speed=0, 2 ticks -> 18.
- Saturation:
  - set_temp=95 + heater_on for 8 ticks -> 100 after 5 ticks, holds 100.
  - set_temp=-100 -> internal temp -40.
  - cooler_on with fan=15 at -38 -> -40.
- heater_on=cooler_on=1 for 3 ticks at 30 -> temp held at 30, mode=FAULT, conflict=1. Heater only next tick -> mode=HEATING, temp 31, conflict stays 1 until reset.
- set_valid on the same edge as an update (set_temp=50, heater_on=1) -> internal temp 50 with no +1 and no tick; next tick 4 cycles later gives 51. Reset asserted 2 cycles later -> temperature=25 immediately.

Source files
------------

// File: rtl/incubator_pkg.sv
// Shared definitions for the incubator controller / plant pair.
//   mode_e      : plant mode encoding (IDLE/HEATING/COOLING/FAULT)
//   TEMP_W      : temperature width (signed)
//   TMIN_DEF/TMAX_DEF : default saturation bounds
//   fan_level() : fan command to cooling level 1..4
//   clamp_temp(): saturate a 10-bit signed value into [lo, hi]
package incubator_pkg;

    localparam int unsigned TEMP_W = 8;

    localparam logic signed [TEMP_W-1:0] TMIN_DEF = -8'sd40;
    localparam logic signed [TEMP_W-1:0] TMAX_DEF = 8'sd100;

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_HEATING = 2'd1,
        MODE_COOLING = 2'd2,
        MODE_FAULT   = 2'd3
    } mode_e;

    // Only the upper two bits of the fan command select the level.
    function automatic logic [2:0] fan_level(input logic [3:0] fan_speed);
        return {1'b0, fan_speed[3:2]} + 3'd1;
    endfunction

    function automatic logic signed [TEMP_W-1:0] clamp_temp(
        input logic signed [9:0]        value,
        input logic signed [TEMP_W-1:0] lo,
        input logic signed [TEMP_W-1:0] hi
    );
        logic signed [9:0] lo_w;
        logic signed [9:0] hi_w;
        lo_w = {{(10-TEMP_W){lo[TEMP_W-1]}}, lo};
        hi_w = {{(10-TEMP_W){hi[TEMP_W-1]}}, hi};
        if (value < lo_w) begin
            return lo;
        end else if (value > hi_w) begin
            return hi;
        end else begin
            return value[TEMP_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sensor_delay_line.sv
// Fixed-latency sensor model: dout is din delayed SENSE_LAT clock cycles.
//   clk        : system clock
//   reset      : asynchronous active-low reset, fills every stage with fill_value
//   fill_value : value loaded into all stages on reset
//   din        : value to delay
//   dout       : delayed value (din itself when SENSE_LAT == 0)
module sensor_delay_line #(
    parameter int unsigned SENSE_LAT = 2,
    parameter int unsigned WIDTH     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] fill_value,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (SENSE_LAT == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_delay
        logic [WIDTH-1:0] stage_q [SENSE_LAT];
        logic [WIDTH-1:0] stage_d [SENSE_LAT];

        always_comb begin
            stage_d[0] = din;
            for (int unsigned i = 1; i < SENSE_LAT; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int unsigned i = 0; i < SENSE_LAT; i++) begin
                    stage_q[i] <= fill_value;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[SENSE_LAT-1];
    end

endmodule

// File: rtl/incubator_plant.sv
// Thermal model of the incubator chamber, closing the loop around the
// incubator controller.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   heater_on   : heater command
//   cooler_on   : cooler command
//   fan_speed   : fan command, level = fan_speed[3:2]+1
//   set_valid   : force-temperature strobe
//   set_temp    : forced temperature (signed, clamped to [TMIN,TMAX])
//   temperature : internal temperature delayed SENSE_LAT cycles (signed)
//   tick        : one-cycle pulse after each thermal update
//   mode        : IDLE/HEATING/COOLING/FAULT, updated at each tick
//   conflict    : sticky, heater and cooler seen together at an update
module incubator_plant
    import incubator_pkg::*;
#(
    parameter logic signed [TEMP_W-1:0] INIT_TEMP = 8'sd25,
    parameter logic signed [TEMP_W-1:0] AMBIENT   = 8'sd25,
    parameter int unsigned              TICK_DIV  = 4,
    parameter int unsigned              HEAT_STEP = 1,
    parameter int unsigned              COOL_STEP = 1,
    parameter logic signed [TEMP_W-1:0] TMIN      = TMIN_DEF,
    parameter logic signed [TEMP_W-1:0] TMAX      = TMAX_DEF,
    parameter int unsigned              SENSE_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     heater_on,
    input  logic                     cooler_on,
    input  logic [3:0]               fan_speed,
    input  logic                     set_valid,
    input  logic signed [TEMP_W-1:0] set_temp,
    output logic signed [TEMP_W-1:0] temperature,
    output logic                     tick,
    output logic [1:0]               mode,
    output logic                     conflict
);

    localparam logic [7:0]        CTR_LAST = 8'(TICK_DIV - 1);
    localparam logic signed [9:0] HEAT_W   = 10'(HEAT_STEP);
    localparam logic signed [9:0] COOL_W   = 10'(COOL_STEP);

    logic signed [TEMP_W-1:0] temp_q, temp_d;
    logic [7:0]               ctr_q, ctr_d;
    logic                     tick_q, tick_d;
    mode_e                    mode_q, mode_d;
    logic                     conflict_q, conflict_d;

    logic                     update;
    logic signed [9:0]        temp_ext;
    logic signed [9:0]        set_ext;
    logic signed [9:0]        lvl_w;
    logic signed [9:0]        next_raw;

    assign update = (ctr_q == CTR_LAST);

    always_comb begin
        temp_ext   = {{(10-TEMP_W){temp_q[TEMP_W-1]}}, temp_q};
        set_ext    = {{(10-TEMP_W){set_temp[TEMP_W-1]}}, set_temp};
        lvl_w      = signed'({7'b0, fan_level(fan_speed)});
        next_raw   = temp_ext;
        temp_d     = temp_q;
        ctr_d      = update ? '0 : ctr_q + 8'd1;
        tick_d     = 1'b0;
        mode_d     = mode_q;
        conflict_d = conflict_q;

        // A force pre-empts a coincident update entirely: no delta, no tick,
        // mode untouched, and the divider restarts from the force edge.
        if (set_valid) begin
            temp_d = clamp_temp(set_ext, TMIN, TMAX);
            ctr_d  = '0;
        end else if (update) begin
            tick_d = 1'b1;
            case ({heater_on, cooler_on})
                2'b10: begin
                    next_raw = temp_ext + HEAT_W;
                    mode_d   = MODE_HEATING;
                end
                2'b01: begin
                    next_raw = temp_ext - COOL_W * lvl_w;
                    mode_d   = MODE_COOLING;
                end
                2'b11: begin
                    mode_d     = MODE_FAULT;
                    conflict_d = 1'b1;
                end
                default: begin
                    if (temp_q < AMBIENT) begin
                        next_raw = temp_ext + 10'sd1;
                    end else if (temp_q > AMBIENT) begin
                        next_raw = temp_ext - 10'sd1;
                    end
                    mode_d = MODE_IDLE;
                end
            endcase
            temp_d = clamp_temp(next_raw, TMIN, TMAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            temp_q     <= INIT_TEMP;
            ctr_q      <= '0;
            tick_q     <= 1'b0;
            mode_q     <= MODE_IDLE;
            conflict_q <= 1'b0;
        end else begin
            temp_q     <= temp_d;
            ctr_q      <= ctr_d;
            tick_q     <= tick_d;
            mode_q     <= mode_d;
            conflict_q <= conflict_d;
        end
    end

    sensor_delay_line #(
        .SENSE_LAT (SENSE_LAT),
        .WIDTH     (TEMP_W)
    ) u_sense (
        .clk        (clk),
        .reset      (reset),
        .fill_value (INIT_TEMP),
        .din        (temp_q),
        .dout       (temperature)
    );

    assign tick     = tick_q;
    assign mode     = mode_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_incubator_plant.sv
// Scoreboard bench for incubator_plant: stimulus pushes the hand-computed
// result of every thermal update; the monitor pops one entry per tick and
// compares mode/conflict in the tick cycle and the sensed temperature two
// cycles after the update edge.
module tb_incubator_plant;

    logic              clk = 1'b0;
    logic              reset;
    logic              heater_on;
    logic              cooler_on;
    logic [3:0]        fan_speed;
    logic              set_valid;
    logic signed [7:0] set_temp;
    logic signed [7:0] temperature;
    logic              tick;
    logic [1:0]        mode;
    logic              conflict;

    typedef struct {
        int temp;
        int mode;
        int conf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    incubator_plant dut (
        .clk         (clk),
        .reset       (reset),
        .heater_on   (heater_on),
        .cooler_on   (cooler_on),
        .fan_speed   (fan_speed),
        .set_valid   (set_valid),
        .set_temp    (set_temp),
        .temperature (temperature),
        .tick        (tick),
        .mode        (mode),
        .conflict    (conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic push(input int t, input int m, input int c);
        exp_t e;
        e.temp = t;
        e.mode = m;
        e.conf = c;
        exp_q.push_back(e);
    endtask

    // Returns at the falling edge inside the next tick cycle (bounded).
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 16);
        check("tick_seen", int'(tick), 1);
    endtask

    task automatic force_temp(input int v);
        set_temp  = 8'(v);
        set_valid = 1'b1;
        @(negedge clk);
        set_valid = 1'b0;
    endtask

    // Monitor: one scoreboard entry per tick.
    initial begin
        int   m;
        int   c;
        int   t;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tick === 1'b1) begin
                m = int'(mode);
                c = int'(conflict);
                @(negedge clk);
                @(negedge clk);
                t = int'($signed(temperature));
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_tick at %0t: got temp=%0d mode=%0d with no expected entry",
                             $time, t, m);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_mode", m, e.mode);
                    check("sb_conflict", c, e.conf);
                    check("sb_temp", t, e.temp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;
        reset     = 1'b0;
        heater_on = 1'b0;
        cooler_on = 1'b0;
        fan_speed = 4'd0;
        set_valid = 1'b0;
        set_temp  = 8'sd0;

        repeat (3) @(negedge clk);
        check("rst_temp", int'($signed(temperature)), 25);
        check("rst_mode", int'(mode), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_conflict", int'(conflict), 0);

        // Idle at ambient: 10 ticks in 40 cycles, temperature constant.
        reset = 1'b1;
        for (int k = 0; k < 10; k++) push(25, 0, 0);
        nt = 0;
        repeat (40) begin
            @(negedge clk);
            if (tick) nt++;
        end
        check("idle_tick_count", nt, 10);

        // Heat 10 ticks: 26..35; output lags the update edge by 2 cycles.
        heater_on = 1'b1;
        for (int k = 1; k <= 10; k++) push(25 + k, 1, 0);
        repeat (10) wait_tick();
        @(negedge clk);
        check("heat_latency_prev", int'($signed(temperature)), 34);

        // Cool with fan level 3 then level 1.
        heater_on = 1'b0;
        cooler_on = 1'b1;
        fan_speed = 4'd8;
        for (int k = 1; k <= 5; k++) push(35 - 3 * k, 2, 0);
        repeat (5) wait_tick();
        fan_speed = 4'd0;
        push(19, 2, 0);
        push(18, 2, 0);
        repeat (2) wait_tick();

        // Upper saturation.
        cooler_on = 1'b0;
        heater_on = 1'b1;
        force_temp(95);
        push(96, 1, 0);
        push(97, 1, 0);
        push(98, 1, 0);
        push(99, 1, 0);
        for (int k = 0; k < 4; k++) push(100, 1, 0);
        repeat (8) wait_tick();

        // Forced value below TMIN is clamped; idle drift then moves up.
        heater_on = 1'b0;
        force_temp(-100);
        @(negedge clk);
        @(negedge clk);
        check("force_clamp_low", int'($signed(temperature)), -40);
        push(-39, 0, 0);
        wait_tick();

        // Lower saturation under max cooling.
        cooler_on = 1'b1;
        fan_speed = 4'd15;
        force_temp(-38);
        push(-40, 2, 0);
        push(-40, 2, 0);
        repeat (2) wait_tick();

        // Heater and cooler together: hold, FAULT, sticky conflict.
        heater_on = 1'b1;
        cooler_on = 1'b1;
        fan_speed = 4'd0;
        force_temp(30);
        for (int k = 0; k < 3; k++) push(30, 3, 1);
        repeat (3) wait_tick();
        cooler_on = 1'b0;
        push(31, 1, 1);
        wait_tick();

        // Force on the same edge as an update.
        repeat (3) @(negedge clk);
        set_temp  = 8'sd50;
        set_valid = 1'b1;
        @(negedge clk);
        set_valid = 1'b0;
        check("force_no_tick", int'(tick), 0);
        check("pre_force_temp", int'($signed(temperature)), 31);
        repeat (2) @(negedge clk);
        check("force_over_update", int'($signed(temperature)), 50);
        push(51, 1, 1);
        wait_tick();

        // Asynchronous reset mid-interval.
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_temp", int'($signed(temperature)), 25);
        check("async_rst_mode", int'(mode), 0);
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_conflict", int'(conflict), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
